// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// master = word producer / serial consumer side, slave = serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             out;
  logic             out_valid;
  logic             done;

  modport master (
    output data_in, load_valid,
    input  load_ready, out, out_valid, done
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, out, out_valid, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, LSB first, valid/ready load.
// Define PIPO_PARITY_EN to append an even-parity bit after each frame.
module piso_serializer #(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  piso_serializer_if.slave     bus
);

  localparam int CW = $clog2(WIDTH);

`ifdef PIPO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
  logic             r_par;
`else
  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_out;
  logic             r_out_valid;
  logic             r_load_ready;
  logic             r_done;

  // Outputs are registered alongside the state, so each branch sets the
  // values that the next state decodes to (out tracks the next shreg[0]).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
`ifdef PIPO_PARITY_EN
      r_par        <= 1'b0;
`endif
      r_out        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_load_ready <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.load_valid) begin
            r_state      <= S_SHIFT;
            r_shreg      <= bus.data_in;
            r_cnt        <= '0;
`ifdef PIPO_PARITY_EN
            r_par        <= ^bus.data_in;
`endif
            r_out        <= bus.data_in[0];
            r_out_valid  <= 1'b1;
            r_load_ready <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_shreg <= r_shreg >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef PIPO_PARITY_EN
            r_state <= S_PARITY;
            r_out   <= r_par;
`else
            r_state      <= S_IDLE;
            r_out        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_load_ready <= 1'b1;
            r_done       <= 1'b1;
`endif
          end else begin
            r_out <= r_shreg[1];
          end
        end
`ifdef PIPO_PARITY_EN
        S_PARITY: begin
          r_state      <= S_IDLE;
          r_out        <= 1'b0;
          r_out_valid  <= 1'b0;
          r_load_ready <= 1'b1;
          r_done       <= 1'b1;
        end
`endif
        default: begin
          r_state      <= S_IDLE;
          r_out        <= 1'b0;
          r_out_valid  <= 1'b0;
          r_load_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.out        = r_out;
  assign bus.out_valid  = r_out_valid;
  assign bus.load_ready = r_load_ready;
  assign bus.done       = r_done;

endmodule
